// File: rtl/atm_ctrl_param.sv
// rtl/atm_ctrl_param.sv - parametrised single-account ATM controller (optional face check: ATM_FACE_RECOG_EN)
module atm_ctrl_param #(
  parameter int BAL_W        = 16,
  parameter int PIN_W        = 4,
  parameter int PIN_CODE     = 0,
  parameter int INIT_BAL     = 20000,
  parameter int MAX_TRIES    = 3,
  parameter int WD_LIMIT     = 10000,
  parameter int FACE_TIMEOUT = 16,
  parameter int HIST_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic             face_recog,
  input  logic             logout,
  output logic             authenticated,
  output logic             account_locked,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W:0]   hist_data,
  output logic             hist_valid,
  output logic             hist_last
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TR_W  = $clog2(MAX_TRIES + 1);

  localparam logic [PIN_W-1:0] PIN_V  = PIN_W'(PIN_CODE);
  localparam logic [BAL_W-1:0] INIT_V = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] WDL_V  = BAL_W'(WD_LIMIT);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_PIN  = 3'd1;
  localparam logic [2:0] ST_LOCKED   = 3'd2;
  localparam logic [2:0] ST_INSUFF   = 3'd3;
  localparam logic [2:0] ST_LIMIT    = 3'd4;
  localparam logic [2:0] ST_FACEFAIL = 3'd5;
  localparam logic [2:0] ST_OVERFLOW = 3'd6;
  localparam logic [2:0] ST_ILLEGAL  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_AUTH      = 3'd1,
    S_FACE_WAIT = 3'd2,
    S_STMT      = 3'd3,
    S_LOCKED    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [BAL_W-1:0] bal_q, bal_d;
  logic [TR_W-1:0]  tries_q, tries_d;
  logic             done_q, done_d;
  logic [2:0]       status_q, status_d;
  logic [BAL_W:0]   hdata_q, hdata_d;
  logic             hvalid_q, hvalid_d;
  logic             hlast_q, hlast_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  logic [BAL_W:0]   mem [HIST_DEPTH];
  logic             log_en;
  logic [BAL_W:0]   log_data;

  logic [PTR_W-1:0] newest_ptr;
  logic [BAL_W:0]   dep_sum;

`ifdef ATM_FACE_RECOG_EN
  localparam int FT_W = $clog2(FACE_TIMEOUT + 1);
  logic [BAL_W-1:0] pend_q, pend_d;
  logic [FT_W-1:0]  fw_q, fw_d;
`else
  logic unused_face;
  assign unused_face = face_recog;
`endif

  assign newest_ptr = wr_ptr_q - 1'b1;
  assign dep_sum    = {1'b0, bal_q} + {1'b0, amount};

  assign authenticated  = (state_q == S_AUTH) || (state_q == S_FACE_WAIT) || (state_q == S_STMT);
  assign account_locked = (state_q == S_LOCKED);
  assign busy           = (state_q == S_FACE_WAIT) || (state_q == S_STMT);
  assign done           = done_q;
  assign status         = status_q;
  assign balance        = bal_q;
  assign hist_data      = hdata_q;
  assign hist_valid     = hvalid_q;
  assign hist_last      = hlast_q;

  // Next-state, datapath updates and registered-output values for the session FSM
  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    tries_d  = tries_q;
    done_d   = 1'b0;
    status_d = status_q;
    hdata_d  = '0;
    hvalid_d = 1'b0;
    hlast_d  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    log_en   = 1'b0;
    log_data = '0;
`ifdef ATM_FACE_RECOG_EN
    pend_d   = pend_q;
    fw_d     = fw_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pin_valid) begin
          done_d = 1'b1;
          if (pin == PIN_V) begin
            state_d  = S_AUTH;
            tries_d  = '0;
            status_d = ST_OK;
          end else if (tries_q + 1'b1 >= TR_W'(MAX_TRIES)) begin
            state_d  = S_LOCKED;
            tries_d  = tries_q + 1'b1;
            status_d = ST_LOCKED;
          end else begin
            tries_d  = tries_q + 1'b1;
            status_d = ST_BAD_PIN;
          end
        end else if (op_valid) begin
          done_d   = 1'b1;
          status_d = ST_ILLEGAL;
        end
      end

      S_AUTH: begin
        if (logout) begin
          state_d = S_IDLE;
        end else if (op_valid) begin
          case (op)
            2'd0: begin
              if (amount > bal_q) begin
                done_d   = 1'b1;
                status_d = ST_INSUFF;
              end else if (amount > WDL_V) begin
`ifdef ATM_FACE_RECOG_EN
                state_d = S_FACE_WAIT;
                pend_d  = amount;
                fw_d    = '0;
`else
                done_d   = 1'b1;
                status_d = ST_LIMIT;
`endif
              end else begin
                done_d   = 1'b1;
                status_d = ST_OK;
                bal_d    = bal_q - amount;
                if (amount != '0) begin
                  log_en   = 1'b1;
                  log_data = {1'b0, amount};
                end
              end
            end
            2'd1: begin
              done_d = 1'b1;
              if (dep_sum[BAL_W]) begin
                status_d = ST_OVERFLOW;
              end else begin
                status_d = ST_OK;
                bal_d    = dep_sum[BAL_W-1:0];
                if (amount != '0) begin
                  log_en   = 1'b1;
                  log_data = {1'b1, amount};
                end
              end
            end
            2'd2: begin
              done_d   = 1'b1;
              status_d = ST_OK;
            end
            default: begin
              // Beat 0 is loaded on the accepting edge so the stream starts one cycle later
              if (cnt_q == '0) begin
                done_d   = 1'b1;
                status_d = ST_OK;
              end else begin
                state_d  = S_STMT;
                hvalid_d = 1'b1;
                hdata_d  = mem[newest_ptr];
                hlast_d  = (cnt_q == CNT_W'(1));
                rd_ptr_d = wr_ptr_q - PTR_W'(2);
                remain_d = cnt_q - 1'b1;
              end
            end
          endcase
        end
      end

`ifdef ATM_FACE_RECOG_EN
      S_FACE_WAIT: begin
        if (logout) begin
          done_d   = 1'b1;
          status_d = ST_FACEFAIL;
          state_d  = S_IDLE;
        end else if (face_recog) begin
          done_d   = 1'b1;
          status_d = ST_OK;
          bal_d    = bal_q - pend_q;
          log_en   = 1'b1;
          log_data = {1'b0, pend_q};
          state_d  = S_AUTH;
        end else if (fw_q == FT_W'(FACE_TIMEOUT - 1)) begin
          done_d   = 1'b1;
          status_d = ST_FACEFAIL;
          state_d  = S_AUTH;
        end else begin
          fw_d = fw_q + 1'b1;
        end
      end
`endif

      S_STMT: begin
        if (remain_q == '0) begin
          done_d   = 1'b1;
          status_d = ST_OK;
          state_d  = S_AUTH;
        end else begin
          hvalid_d = 1'b1;
          hdata_d  = mem[rd_ptr_q];
          hlast_d  = (remain_q == CNT_W'(1));
          rd_ptr_d = rd_ptr_q - 1'b1;
          remain_d = remain_q - 1'b1;
        end
      end

      S_LOCKED: begin
        if (pin_valid || op_valid) begin
          done_d   = 1'b1;
          status_d = ST_LOCKED;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ring pointer wraps naturally because HIST_DEPTH is a power of two
    if (log_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != CNT_W'(HIST_DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State, balance, history and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bal_q    <= INIT_V;
      tries_q  <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      hdata_q  <= '0;
      hvalid_q <= 1'b0;
      hlast_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      remain_q <= '0;
`ifdef ATM_FACE_RECOG_EN
      pend_q   <= '0;
      fw_q     <= '0;
`endif
      for (int i = 0; i < HIST_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      tries_q  <= tries_d;
      done_q   <= done_d;
      status_q <= status_d;
      hdata_q  <= hdata_d;
      hvalid_q <= hvalid_d;
      hlast_q  <= hlast_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
`ifdef ATM_FACE_RECOG_EN
      pend_q   <= pend_d;
      fw_q     <= fw_d;
`endif
      if (log_en) begin
        mem[wr_ptr_q] <= log_data;
      end
    end
  end

endmodule

// File: tb/tb_atm_ctrl_param.sv
// tb/tb_atm_ctrl_param.sv - randomized bench for atm_ctrl_param against a transaction-level model
module tb_atm_ctrl_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  pin = '0;
  logic        pin_valid = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = '0;
  logic [15:0] amount = '0;
  logic        face_recog = 1'b0;
  logic        logout = 1'b0;
  logic        authenticated, account_locked, busy, done, hist_valid, hist_last;
  logic [2:0]  status;
  logic [15:0] balance;
  logic [16:0] hist_data;

  atm_ctrl_param dut (
    .clk(clk), .reset(reset), .pin(pin), .pin_valid(pin_valid),
    .op_valid(op_valid), .op(op), .amount(amount), .face_recog(face_recog),
    .logout(logout), .authenticated(authenticated), .account_locked(account_locked),
    .busy(busy), .done(done), .status(status), .balance(balance),
    .hist_data(hist_data), .hist_valid(hist_valid), .hist_last(hist_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int beat_cnt = 0;

  // model state
  int m_bal;
  int m_tries;
  bit m_auth;
  bit m_locked;
  int hist[$];

  // expected per-cycle outputs
  logic        e_done = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_hv = 1'b0;
  logic        e_hl = 1'b0;
  logic [2:0]  e_status = 3'd0;
  logic [16:0] e_hd = '0;
  bit          chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("done", 32'(done), 32'(e_done));
      cmp("status", 32'(status), 32'(e_status));
      cmp("balance", 32'(balance), 32'(m_bal));
      cmp("authenticated", 32'(authenticated), 32'(m_auth));
      cmp("account_locked", 32'(account_locked), 32'(m_locked));
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("hist_valid", 32'(hist_valid), 32'(e_hv));
      cmp("hist_last", 32'(hist_last), 32'(e_hl));
      if (e_hv) cmp("hist_data", 32'(hist_data), 32'(e_hd));
      if (hist_valid) beat_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    e_done = 1'b0;
    e_hv   = 1'b0;
    e_hl   = 1'b0;
    e_busy = 1'b0;
  endtask

  task automatic m_reset();
    m_bal    = 20000;
    m_tries  = 0;
    m_auth   = 1'b0;
    m_locked = 1'b0;
    hist.delete();
    e_status = 3'd0;
    e_hd     = '0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0; pin_valid = 1'b0; op_valid = 1'b0; face_recog = 1'b0; logout = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      m_reset();
    end
    reset = 1'b1;
  endtask

  task automatic log_entry(input int typ, input int amt);
    if (amt != 0) begin
      hist.push_back(typ * 65536 + amt);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  endtask

  task automatic do_pin(input int p);
    pin = 4'(p); pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
    if (m_locked) begin
      e_done = 1'b1; e_status = 3'd2;
    end else if (!m_auth) begin
      e_done = 1'b1;
      if (p == 0) begin
        m_auth = 1'b1; m_tries = 0; e_status = 3'd0;
      end else begin
        m_tries++;
        if (m_tries >= 3) begin m_locked = 1'b1; e_status = 3'd2; end
        else e_status = 3'd1;
      end
    end
    step();
  endtask

  task automatic do_logout();
    logout = 1'b1;
    step();
    logout = 1'b0;
    m_auth = 1'b0;
  endtask

`ifdef ATM_FACE_RECOG_EN
  task automatic face_wait(input int amt, input int face_at);
    e_busy = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      face_recog = (t == face_at);
      step();
      face_recog = 1'b0;
      if (t == face_at) begin
        m_bal -= amt; log_entry(0, amt); e_done = 1'b1; e_status = 3'd0; return;
      end
      if (t == 16) begin
        e_done = 1'b1; e_status = 3'd5; return;
      end
      e_busy = 1'b1;
    end
  endtask
`endif

  task automatic statement(input bit inject);
    int n;
    n = hist.size();
    if (n == 0) begin
      e_done = 1'b1; e_status = 3'd0;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          if (inject && i == 1) begin op_valid = 1'b1; op = 2'd1; amount = 16'd777; end
          step();
          op_valid = 1'b0;
        end
        e_busy = 1'b1; e_hv = 1'b1; e_hl = (i == n - 1); e_hd = 17'(hist[n - 1 - i]);
      end
      step();
      e_done = 1'b1; e_status = 3'd0;
    end
  endtask

  task automatic do_op(input int o, input int amt, input int face_at, input bit inject);
    op = 2'(o); amount = 16'(amt); op_valid = 1'b1;
    face_recog = (face_at != 0);
    step();
    op_valid = 1'b0; face_recog = 1'b0;
    if (m_locked) begin
      e_done = 1'b1; e_status = 3'd2;
    end else if (!m_auth) begin
      e_done = 1'b1; e_status = 3'd7;
    end else begin
      case (o)
        0: begin
          if (amt > m_bal) begin
            e_done = 1'b1; e_status = 3'd3;
          end else if (amt > 10000) begin
`ifdef ATM_FACE_RECOG_EN
            face_wait(amt, face_at);
`else
            e_done = 1'b1; e_status = 3'd4;
`endif
          end else begin
            m_bal -= amt; log_entry(0, amt); e_done = 1'b1; e_status = 3'd0;
          end
        end
        1: begin
          if (m_bal + amt > 65535) begin
            e_done = 1'b1; e_status = 3'd6;
          end else begin
            m_bal += amt; log_entry(1, amt); e_done = 1'b1; e_status = 3'd0;
          end
        end
        2: begin
          e_done = 1'b1; e_status = 3'd0;
        end
        default: statement(inject);
      endcase
    end
    step();
  endtask

  initial begin
    int b0;
    int r;
    int a;
    m_reset();
    do_reset(2);
    chk_en = 1'b1;
    cmp("reset_balance", 32'(balance), 32'd20000);
    cmp("reset_status", 32'(status), 32'd0);
    cmp("reset_hist_data", 32'(hist_data), 32'd0);
    cmp("reset_flags", 32'({authenticated, account_locked, busy, done, hist_valid, hist_last}), 32'd0);

    // lockout after three bad PINs
    do_pin(1); do_pin(2); do_pin(4);
    cmp("lock_flag", 32'(account_locked), 32'd1);
    do_pin(0);
    cmp("locked_pin0_status", 32'(status), 32'd2);
    do_op(2, 0, 0, 1'b0);

    // plain withdraw, op in IDLE is illegal
    do_reset(2);
    do_op(0, 100, 0, 1'b0);
    cmp("idle_op_status", 32'(status), 32'd7);
    do_pin(0);
    do_op(0, 5000, 0, 1'b0);
    cmp("wd5000_balance", 32'(balance), 32'd15000);

    // large withdraw: face path or LIMIT depending on build
    do_reset(2);
    do_pin(0);
    do_op(0, 15000, 3, 1'b0);
`ifdef ATM_FACE_RECOG_EN
    cmp("wd15000_balance", 32'(balance), 32'd5000);
    do_reset(2);
    do_pin(0);
`else
    cmp("wd15000_balance", 32'(balance), 32'd20000);
    cmp("wd15000_status", 32'(status), 32'd4);
`endif
    do_op(0, 12000, 0, 1'b0);
    cmp("wd12000_balance", 32'(balance), 32'd20000);
    do_op(0, 25000, 0, 1'b0);
    cmp("wd25000_status", 32'(status), 32'd3);

    // deposits and overflow, then statement with empty and full history
    do_reset(2);
    do_pin(0);
    beat_cnt = 0;
    do_op(3, 0, 0, 1'b0);
    cmp("empty_stmt_beats", 32'(beat_cnt), 32'd0);
    do_op(1, 2000, 0, 1'b0);
    cmp("dep2000_balance", 32'(balance), 32'd22000);
    do_op(1, 60000, 0, 1'b0);
    cmp("dep60000_status", 32'(status), 32'd6);
    do_op(1, 0, 0, 1'b0);
    do_op(0, 0, 0, 1'b0);
    do_op(1, 100, 0, 1'b0);
    do_op(1, 300, 0, 1'b0);
    do_op(0, 50, 0, 1'b0);
    do_op(1, 400, 0, 1'b0);
    beat_cnt = 0;
    do_op(3, 0, 0, 1'b1);
    cmp("stmt_beats", 32'(beat_cnt), 32'd4);
    cmp("dropped_op_balance", 32'(balance), 32'd22750);

    // logout keeps balance; op afterwards is illegal
    b0 = m_bal;
    do_logout();
    do_op(1, 10, 0, 1'b0);
    cmp("persist_balance", 32'(balance), 32'(b0));
    do_pin(0);

    // reset in the middle of a statement stream
    op = 2'd3; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    e_busy = 1'b1; e_hv = 1'b1; e_hl = (hist.size() == 1); e_hd = 17'(hist[hist.size() - 1]);
    do_reset(2);
    cmp("midstmt_reset_hv", 32'(hist_valid), 32'd0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
      end else if (r < 14) begin
        do_pin(($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 0);
      end else if (r < 20) begin
        do_logout();
      end else begin
        case ($urandom_range(0, 3))
          0: a = $urandom_range(0, 3000);
          1: a = $urandom_range(9990, 10010);
          2: a = $urandom_range(0, 65535);
          default: a = 0;
        endcase
        do_op($urandom_range(0, 3), a, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atm_ctrl_param.md
# atm_ctrl_param

Parametrised single-account ATM controller. Generalises the original ATM block with configurable balance, PIN and history widths, a valid-strobe operation interface, a bounded face-recognition wait for large withdrawals, and a circular transaction history streamed as a mini statement. It sits between the keypad/card front end and the display/printer back end, one instance per session slot.

## Interface
- `BAL_W`, 16, balance and amount width (bits)
- `PIN_W`, 4, PIN width
- `PIN_CODE`, 0, correct PIN value
- `INIT_BAL`, 20000, balance loaded at reset
- `MAX_TRIES`, 3, consecutive bad PINs before lockout
- `WD_LIMIT`, 10000, largest withdrawal that needs no face check
- `FACE_TIMEOUT`, 16, cycles to wait for `face_recog`
- `HIST_DEPTH`, 4, history entries (power of two, ≥2)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `pin` in PIN_W: entered PIN
- `pin_valid` in 1: one-cycle strobe, PIN present
- `op_valid` in 1: one-cycle strobe, operation request
- `op` in 2: 0 withdraw, 1 deposit, 2 balance display, 3 mini statement
- `amount` in BAL_W: withdraw/deposit amount, sampled with `op_valid`
- `face_recog` in 1: face check pass, level
- `logout` in 1: end session
- `authenticated` out 1: session open
- `account_locked` out 1: lockout latched
- `busy` out 1: not accepting `op_valid`
- `done` out 1: one-cycle completion pulse
- `status` out 3: 0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFF, 4 LIMIT, 5 FACE_FAIL, 6 OVERFLOW, 7 ILLEGAL; valid with `done`, held until next `done`
- `balance` out BAL_W: current balance
- `hist_data` out BAL_W+1: {type (1 = deposit), amount}
- `hist_valid` out 1: statement beat valid
- `hist_last` out 1: final statement beat

## Operation
- States: IDLE, AUTH, FACE_WAIT, STMT, LOCKED.
- IDLE: `pin_valid` compares `pin` with `PIN_CODE`. Match → AUTH, try counter cleared, status OK. Mismatch → counter+1, status BAD_PIN. On the MAX_TRIES-th consecutive miss → LOCKED, status LOCKED. `op_valid` in IDLE → status ILLEGAL. `pin_valid` wins when both strobes are high.
- LOCKED: `account_locked`=1. Every strobe returns status LOCKED. Exits only via reset.
- AUTH withdraw: amount > balance → INSUFF. amount > WD_LIMIT → FACE_WAIT (see Configuration). Otherwise balance −= amount, status OK.
- AUTH deposit: balance + amount computed at BAL_W+1 bits. Carry set → OVERFLOW and balance unchanged. Otherwise balance updated, status OK.
- AUTH balance display: status OK, no state change.
- Only successful withdraw/deposit with amount ≠ 0 is written to the history ring at the write pointer. Pointer wraps modulo HIST_DEPTH and overwrites the oldest entry. An entry count saturates at HIST_DEPTH.
- FACE_WAIT: `face_recog`=1 → debit, log, status OK, return to AUTH. Timeout counter reaching FACE_TIMEOUT → FACE_FAIL, return to AUTH, balance unchanged.
- STMT: streams the count entries newest-first, one per cycle, `hist_last` on the final entry, then `done` with status OK. With count = 0, `done` with OK and no beats.
- `logout` in AUTH → IDLE. `logout` in FACE_WAIT → FACE_FAIL, then IDLE. `logout` in STMT is ignored until the stream ends. Balance and history persist across sessions.
- `op_valid` while `busy` is dropped silently.

## Timing
- Reset values: state IDLE, `balance`=INIT_BAL, history count 0, write pointer 0, try counter 0. All flag outputs 0, `status` 0, `hist_data` 0.
- PIN check and withdraw/deposit/balance ops: `done` the cycle after the strobe. `balance` updates on the same edge.
- FACE_WAIT: `busy`=1 from the cycle after acceptance. `done` follows `face_recog` high by 1 cycle, or occurs at timeout, FACE_TIMEOUT cycles after entry.
- STMT: first beat 1 cycle after acceptance, N consecutive beats, `done` in the cycle after `hist_last`.
- Reset asserted mid-FACE_WAIT or mid-STMT aborts the operation at that edge with no debit.

## Configuration
- `ATM_FACE_RECOG_EN` defined: withdrawals above WD_LIMIT enter FACE_WAIT as described.
- Not defined: such withdrawals complete immediately with status LIMIT. FACE_WAIT and its counter are removed and `face_recog` is ignored.

## Test plan
- PINs 1, 2, 4 → BAD_PIN, BAD_PIN, LOCKED with `account_locked`=1. A following PIN 0 → LOCKED.
- PIN 0, withdraw 5000 → OK, `balance`=15000, 1-cycle latency.
- PIN 0, withdraw 15000 with `face_recog` high at cycle 3 → OK, `balance`=5000 (macro on). Macro off → LIMIT, `balance`=20000.
- Withdraw 12000, no face → FACE_FAIL after 16 cycles, balance unchanged. Withdraw 25000 → INSUFF.
- Deposit 2000 → `balance`=22000. Deposit 60000 on a 16-bit balance → OVERFLOW, unchanged.
- Five logged transactions with HIST_DEPTH=4, then mini statement → 4 beats newest-first, oldest dropped, `hist_last` on beat 4. Empty history → `done` only.
